// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Multi-cycle SLL/SRL/SRA controller for a bit-serial
//                universal shifter. Loads the operand, issues one-bit shift
//                steps and re-inserts the sign bit after each arithmetic step.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [N-1:0]   req_data,
  input  logic [SHW-1:0] req_shamt,
  output logic [1:0]     sh_s,
  output logic [N-1:0]   sh_i,
  input  logic [N-1:0]   sh_a,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic           busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b11;
  localparam logic [1:0] OP_PASS = 2'b10;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_LOAD  = 2'b11;

  localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [1:0]     op_q;
  logic [N-1:0]   data_q;
  logic           sign_q;
  logic [SHW-1:0] cnt_q;
  logic           accept;

  assign accept = req_valid && (state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Request capture and remaining-step counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= 2'b00;
      data_q <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      data_q <= req_data;
      sign_q <= req_data[N-1];
      // The reserved op is a pass-through: zero steps means LOAD goes straight to DONE
      cnt_q  <= (req_op == OP_PASS) ? '0 : req_shamt;
    end else if (state == S_SHIFT) begin
      cnt_q  <= cnt_q - CNT_ONE;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (cnt_q == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: begin
        if (op_q == OP_SRA)        state_nxt = S_FIX;
        else if (cnt_q == CNT_ONE) state_nxt = S_DONE;
        else                       state_nxt = S_SHIFT;
      end
      // cnt_q was already decremented by the SHIFT cycle before this one
      S_FIX:   state_nxt = (cnt_q == '0) ? S_DONE : S_SHIFT;
      S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shifter control and handshake outputs
  always_comb begin
    sh_s      = SH_HOLD;
    sh_i      = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        sh_s = SH_LOAD;
        sh_i = data_q;
      end
      S_SHIFT: sh_s = (op_q == OP_SLL) ? SH_LEFT : SH_RIGHT;
      S_FIX: begin
        // Reload the shifted value with the zero-filled MSB replaced by the sign
        sh_s = SH_LOAD;
        sh_i = (sh_a & ~MSB_MASK) | (sign_q ? MSB_MASK : '0);
      end
      S_DONE:  rsp_valid = 1'b1;
      default: begin
        sh_s = SH_HOLD;
      end
    endcase
  end

  assign rsp_data = sh_a;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Self-checking bench for shift_sequencer with a behavioural
//                universal-shifter model and an arithmetic result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic [4:0]  req_shamt;
  logic [1:0]  sh_s;
  logic [31:0] sh_i;
  logic [31:0] sh_a;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.N(32), .SHW(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .sh_s      (sh_s),
    .sh_i      (sh_i),
    .sh_a      (sh_a),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Universal shifter: hold / right (zero MSB) / left (zero LSB) / load
  always @(posedge clk or negedge resetn) begin
    if (!resetn) sh_a <= 32'h0;
    else begin
      case (sh_s)
        2'b01:   sh_a <= sh_a >> 1;
        2'b10:   sh_a <= sh_a << 1;
        2'b11:   sh_a <= sh_i;
        default: sh_a <= sh_a;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_sh_s"},      32'(sh_s),      32'd0);
    check({tag, "_sh_i"},      sh_i,           32'd0);
    check({tag, "_rsp_data"},  rsp_data,       32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_req(input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] shamt, input int hold);
    logic signed [31:0] sdata;
    logic [31:0] exp;
    int eff, exp_lat, edges, n_l, n_r, n_ld, bad_si, bad_hold;
    bit got, first;
    sdata = data;
    eff   = (op == 2'b10) ? 0 : int'(shamt);
    case (op)
      2'b00:   exp = data << eff;
      2'b01:   exp = data >> eff;
      2'b11:   exp = sdata >>> eff;
      default: exp = data;
    endcase
    exp_lat = 1 + ((op == 2'b11) ? 2 * eff : eff);

    req_valid = 1'b1; req_op = op; req_data = data; req_shamt = shamt;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble request inputs: they must not matter after acceptance
    req_valid = 1'b0; req_data = $urandom; req_shamt = 5'($urandom); req_op = 2'($urandom);

    got = 0; first = 1; edges = 0; n_l = 0; n_r = 0; n_ld = 0; bad_si = 0;
    while (edges < 200) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
      case (sh_s)
        2'b10: begin n_l++; if (sh_i !== 32'h0) bad_si++; end
        2'b01: begin n_r++; if (sh_i !== 32'h0) bad_si++; end
        2'b11: begin
          n_ld++;
          if (first) begin if (sh_i !== data) bad_si++; end
          else if (sh_i !== {data[31], sh_a[30:0]}) bad_si++;
        end
        default: bad_si++;
      endcase
      if (busy !== 1'b1 || req_ready !== 1'b0) bad_si++;
      first = 0;
      @(posedge clk);
      edges++;
    end
    check("rsp_seen",  32'(got),   32'd1);
    check("latency",   32'(edges), 32'(exp_lat));
    check("n_left",    32'(n_l),   32'((op == 2'b00) ? eff : 0));
    check("n_right",   32'(n_r),   32'((op == 2'b01 || op == 2'b11) ? eff : 0));
    check("n_load",    32'(n_ld),  32'(1 + ((op == 2'b11) ? eff : 0)));
    check("seq_ctrl",  32'(bad_si), 32'd0);
    check("rsp_data",  rsp_data,   exp);
    check("done_sh_s", 32'(sh_s),  32'd0);
    check("done_busy", 32'(busy),  32'd1);
    check("done_rdy",  32'(req_ready), 32'd0);

    bad_hold = 0;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_data = $urandom; req_op = 2'($urandom); req_shamt = 5'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== exp || sh_s !== 2'b00 ||
          sh_i !== 32'h0 || req_ready !== 1'b0) bad_hold++;
    end
    if (hold > 0) check("hold_stable", 32'(bad_hold), 32'd0);

    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_busy",  32'(busy),      32'd0);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = 32'h0;
    req_shamt = 5'd0; rsp_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    run_req(2'b00, 32'h0000_0001, 5'd31, 0);
    run_req(2'b01, 32'h8000_0000, 5'd4,  0);
    run_req(2'b01, 32'hFFFF_FFFF, 5'd31, 0);
    run_req(2'b11, 32'h8000_0000, 5'd4,  0);
    run_req(2'b11, 32'h4000_0000, 5'd1,  0);
    run_req(2'b00, 32'hDEAD_BEEF, 5'd0,  0);
    run_req(2'b01, 32'hDEAD_BEEF, 5'd0,  0);
    run_req(2'b11, 32'hDEAD_BEEF, 5'd0,  0);
    run_req(2'b10, 32'hDEAD_BEEF, 5'd7,  0);
    // Backpressure, then a request immediately after returning to idle
    run_req(2'b00, 32'h0000_1234, 5'd3,  10);
    run_req(2'b11, 32'h8765_4321, 5'd5,  0);

    // Abort during SHIFT of a long SLL
    req_valid = 1'b1; req_op = 2'b00; req_data = 32'h0000_0F0F; req_shamt = 5'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_in_shift", 32'(sh_s), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    resetn = 1'b1;
    run_req(2'b11, 32'hF000_0000, 5'd2, 0);

    // Randomized requests with random backpressure
    for (int t = 0; t < 24; t++) begin
      run_req(2'($urandom), $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
